decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
ID stage of the 5-stage RV32I pipeline. Sits directly downstream of the fetch stage and consumes its IF/ID outputs (InstrD, PCD, PCPlus4D). Decodes the instruction, reads the register file (written back from WB), and generates the sign-extended immediate and control signals. Registers everything into the ID/EX pipeline register for the execute stage.

Parameters:
DATA_W, 32, datapath width
NUM_REGS, 32, architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC from IF/ID
PCPlus4D  in  32  PC+4 from IF/ID
flushE  in  1  sync clear of ID/EX (hazard unit)
RegWriteW  in  1  WB write enable
RdW  in  5  WB destination
ResultW  in  32  WB data
Rs1D, Rs2D  out  5 each  source indices to hazard unit (comb)
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls
ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data
RdE, Rs1E, Rs2E  out  5 each  registered indices

Behaviour:
- Reset: clk; rst asynchronous, active-low. While rst=0, all ID/EX outputs = 0 and all 32 registers = 0.
- Latency: one cycle from IF/ID inputs to *E outputs. Rs1D/Rs2D are combinational: InstrD[19:15] and InstrD[24:20].
- Register file:
  - Write on posedge clk when RegWriteW=1 and RdW!=0. Writes to x0 are ignored.
  - Reads are combinational with same-cycle bypass: if RegWriteW and RdW==rs and rs!=0, read data = ResultW.
  - Reads of x0 always return 0.
- Decode (opcode InstrD[6:0]):
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, ImmSrc I.
  - sw 0100011: MemWrite, ALUSrc, ImmSrc S.
  - R 0110011: RegWrite, ALUOp=10.
  - I-ALU 0010011: RegWrite, ALUSrc, ALUOp=10, ImmSrc I.
  - beq 1100011: Branch, ALUOp=01, ImmSrc B.
  - jal 1101111: RegWrite, Jump, ResultSrc=10, ImmSrc J.
  - Any other opcode, including InstrD=0 (flushD bubble): all controls 0.
- ALU decoder:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10: funct3 000 → sub only if R-type and funct7[5]=1, else add; 010 → slt; 110 → or; 111 → and.
  - Unsupported funct3 → add.
- Immediate generation, all sign-extended from InstrD[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- ID/EX register priority: rst > flushE (all outputs 0 next edge) > load. There is no stall input; the hazard unit stalls only IF/ID.
- Simultaneous WB write and decode read of the same register: the bypassed value is captured into RD1E/RD2E the same edge.
- Reset asserted mid-operation clears both the register file and ID/EX immediately, with no clock required.

Decomposition:
- Shared package/header holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - ALUControl encodings
  - ResultSrc encodings
  - ImmSrc encodings
- Sub-modules:
  - register_file: 32x32, async active-low reset, bypass logic included.
  - Control decode and immediate extension stay inline as combinational blocks.

Test Plan:
- Reset and x0 write: hold rst=0 → all *E outputs 0. Release rst, write x0=0xDEADBEEF via WB → reading x0 returns 0.
- Write-then-read bypass: RegWriteW=1, RdW=5, ResultW=0x1234 with InstrD=add x3,x5,x0 (0x000281B3) in the same cycle → next edge RD1E=0x1234, RegWriteE=1, ALUControlE=000, RdE=3.
- Immediates:
  - lw x1,-4(x2) (0xFFC12083) → ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - sw x1,8(x2) (0x00112423) → ImmExtE=8, MemWriteE=1, RegWriteE=0.
- Branch/jump:
  - beq x1,x2,-8 (0xFE208CE3) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8.
  - jal x1,16 (0x010000EF) → JumpE=1, ResultSrcE=10, ImmExtE=16, PCPlus4E=PCD+4.
- flushE: assert with a valid sub x1,x2,x3 (0x403100B3) on InstrD → next edge all *E outputs 0. Deassert → sub appears with ALUControlE=001.
- Bubble and async reset: InstrD=0 → all controls 0. Assert rst asynchronously mid-cycle → outputs clear before the next clk edge.

Source files
------------

// File: rtl/decode_cycle_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, control fields and the ID/EX bundle.
`timescale 1ns/1ps
package decode_cycle_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // I is the all-zero encoding so undecoded opcodes fall back to it.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic        aluSrc;
        logic [1:0]  resultSrc;
        logic [2:0]  aluControl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] immExt;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idEx_t;

endpackage

// File: rtl/decode_cycle_register_file.sv
// Architectural register file: two combinational read ports with WB bypass, one write port, x0 fixed at zero.
`timescale 1ns/1ps
module register_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] wa,
    input  logic [DATA_W-1:0]           wd,
    input  logic [$clog2(NUM_REGS)-1:0] ra1,
    input  logic [$clog2(NUM_REGS)-1:0] ra2,
    output logic [DATA_W-1:0]           rd1,
    output logic [DATA_W-1:0]           rd2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    // The WB value is forwarded in the same cycle so ID never sees a stale register.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
        if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/decode_cycle.sv
// ID stage: decodes InstrD, reads the register file, builds the immediate and registers it all into ID/EX.
`timescale 1ns/1ps
module decode_cycle
    import decode_cycle_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [DATA_W-1:0] PCD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic              flushE,
    input  logic              RegWriteW,
    input  logic [4:0]        RdW,
    input  logic [DATA_W-1:0] ResultW,
    output logic [4:0]        Rs1D,
    output logic [4:0]        Rs2D,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic [4:0]        RdE,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       isRtype;
    logic       regWriteD, memWriteD, jumpD, branchD, aluSrcD;
    logic [1:0] resultSrcD, immSrcD, aluOpD;
    logic [2:0] aluControlD;
    logic [DATA_W-1:0] rd1D, rd2D, immExtD;
    idEx_t idEx;

    assign opcode  = InstrD[6:0];
    assign funct3  = InstrD[14:12];
    assign isRtype = (opcode == OP_RTYPE);
    assign Rs1D    = InstrD[19:15];
    assign Rs2D    = InstrD[24:20];

    register_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regFile (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RdW),
        .wd  (ResultW),
        .ra1 (Rs1D),
        .ra2 (Rs2D),
        .rd1 (rd1D),
        .rd2 (rd2D)
    );

    always_comb begin
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        jumpD      = 1'b0;
        branchD    = 1'b0;
        aluSrcD    = 1'b0;
        resultSrcD = RES_ALU;
        immSrcD    = IMM_I;
        aluOpD     = ALUOP_ADD;
        unique case (opcode)
            OP_LOAD:   begin regWriteD = 1'b1; aluSrcD = 1'b1; resultSrcD = RES_MEM; end
            OP_STORE:  begin memWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = IMM_S; end
            OP_RTYPE:  begin regWriteD = 1'b1; aluOpD = ALUOP_FUNC; end
            OP_ITYPE:  begin regWriteD = 1'b1; aluSrcD = 1'b1; aluOpD = ALUOP_FUNC; end
            OP_BRANCH: begin branchD = 1'b1; aluOpD = ALUOP_SUB; immSrcD = IMM_B; end
            OP_JAL:    begin regWriteD = 1'b1; jumpD = 1'b1; resultSrcD = RES_PC4; immSrcD = IMM_J; end
            default:   ;
        endcase
    end

    // InstrD[30] is part of the immediate on I-type, so only R-type may select sub.
    always_comb begin
        aluControlD = ALU_ADD;
        case (aluOpD)
            ALUOP_SUB: aluControlD = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  aluControlD = (isRtype && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControlD = ALU_SLT;
                    3'b110:  aluControlD = ALU_OR;
                    3'b111:  aluControlD = ALU_AND;
                    default: aluControlD = ALU_ADD;
                endcase
            end
            default: aluControlD = ALU_ADD;
        endcase
    end

    always_comb begin
        immExtD = '0;
        case (immSrcD)
            IMM_I: immExtD = {{(DATA_W-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: immExtD = {{(DATA_W-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: immExtD = {{(DATA_W-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: immExtD = {{(DATA_W-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: immExtD = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idEx <= '0;
        end else if (flushE) begin
            idEx <= '0;
        end else begin
            idEx <= '{regWrite: regWriteD, memWrite: memWriteD, jump: jumpD, branch: branchD,
                      aluSrc: aluSrcD, resultSrc: resultSrcD, aluControl: aluControlD,
                      rd1: rd1D, rd2: rd2D, immExt: immExtD, pc: PCD, pcPlus4: PCPlus4D,
                      rd: InstrD[11:7], rs1: Rs1D, rs2: Rs2D};
        end
    end

    assign RegWriteE   = idEx.regWrite;
    assign MemWriteE   = idEx.memWrite;
    assign JumpE       = idEx.jump;
    assign BranchE     = idEx.branch;
    assign ALUSrcE     = idEx.aluSrc;
    assign ResultSrcE  = idEx.resultSrc;
    assign ALUControlE = idEx.aluControl;
    assign RD1E        = idEx.rd1;
    assign RD2E        = idEx.rd2;
    assign ImmExtE     = idEx.immExt;
    assign PCE         = idEx.pc;
    assign PCPlus4E    = idEx.pcPlus4;
    assign RdE         = idEx.rd;
    assign Rs1E        = idEx.rs1;
    assign Rs2E        = idEx.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: driver pushes expected ID/EX contents, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_decode_cycle;

    localparam int W = 185;

    // {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    localparam logic [9:0] C_NONE = 10'b0_0_0_0_0_00_000;
    localparam logic [9:0] C_ADD  = 10'b1_0_0_0_0_00_000;
    localparam logic [9:0] C_SUB  = 10'b1_0_0_0_0_00_001;
    localparam logic [9:0] C_AND  = 10'b1_0_0_0_0_00_010;
    localparam logic [9:0] C_SLT  = 10'b1_0_0_0_0_00_101;
    localparam logic [9:0] C_ADDI = 10'b1_0_0_0_1_00_000;
    localparam logic [9:0] C_ORI  = 10'b1_0_0_0_1_00_011;
    localparam logic [9:0] C_LW   = 10'b1_0_0_0_1_01_000;
    localparam logic [9:0] C_SW   = 10'b0_1_0_0_1_00_000;
    localparam logic [9:0] C_BEQ  = 10'b0_0_0_1_0_00_001;
    localparam logic [9:0] C_JAL  = 10'b1_0_1_0_0_10_000;

    logic        clk, rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        flushE, RegWriteW;
    logic [4:0]  RdW, Rs1D, Rs2D, RdE, Rs1E, Rs2E;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] act_vec, exp_e;
    string        exp_n;
    logic         stim_valid, chk_pending;
    int           checks, errors;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .flushE(flushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
    );

    assign act_vec = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                      RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [9:0] ctl, input logic [31:0] rd1, rd2, imm, pc,
                                        input logic [4:0] rd, rs1, rs2);
        return {ctl, rd1, rd2, imm, pc, pc + 32'd4, rd, rs1, rs2};
    endfunction

    // driver tasks
    task automatic check_now(input string nm, input logic [W-1:0] e);
        checks++;
        if (act_vec !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act_vec, e);
        end
    endtask

    task automatic check_rs(input string nm, input logic [4:0] e1, e2);
        checks++;
        if ({Rs1D, Rs2D} !== {e1, e2}) begin
            errors++;
            $display("FAIL %s_rsD got %0d,%0d exp %0d,%0d", nm, Rs1D, Rs2D, e1, e2);
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] instr, pc, input logic flush, wbEn,
                         input logic [4:0] wbRd, input logic [31:0] wbData, input logic [W-1:0] e);
        @(posedge clk); #1;
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; flushE = flush;
        RegWriteW = wbEn; RdW = wbRd; ResultW = wbData; stim_valid = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1 check_rs(nm, instr[19:15], instr[24:20]);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        InstrD = '0; flushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0; stim_valid = 1'b0;
    endtask

    // scoreboard monitor
    always @(posedge clk) chk_pending <= stim_valid;

    always @(negedge clk) begin
        if (chk_pending) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor got %h exp none", act_vec);
            end else begin
                exp_e = exp_q.pop_front();
                exp_n = name_q.pop_front();
                if (act_vec !== exp_e) begin
                    errors++;
                    $display("FAIL %s got %h exp %h", exp_n, act_vec, exp_e);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; stim_valid = 1'b0; chk_pending = 1'b0;
        rst = 1'b0; flushE = 1'b0;
        InstrD = 32'hFFC12083; PCD = 32'h40; PCPlus4D = 32'h44;
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'hAA;
        repeat (2) @(negedge clk);
        check_now("reset_hold", '0);
        RegWriteW = 1'b0;
        rst = 1'b1;

        issue("x0_write",  32'h000001B3, 32'h000, 0, 1, 5'd0, 32'hDEADBEEF, mk(C_ADD, 0, 0, 0, 32'h000, 3, 0, 0));
        issue("x0_read",   32'h000001B3, 32'h004, 0, 0, 5'd0, 32'h0,        mk(C_ADD, 0, 0, 0, 32'h004, 3, 0, 0));
        issue("bypass",    32'h000281B3, 32'h008, 0, 1, 5'd5, 32'h1234,     mk(C_ADD, 32'h1234, 0, 0, 32'h008, 3, 5, 0));
        issue("bubble1",   32'h00000000, 32'h00C, 0, 1, 5'd1, 32'h11,       mk(C_NONE, 0, 0, 0, 32'h00C, 0, 0, 0));
        issue("bubble2",   32'h00000000, 32'h010, 0, 1, 5'd2, 32'h22,       mk(C_NONE, 0, 0, 0, 32'h010, 0, 0, 0));
        issue("lw",        32'hFFC12083, 32'h014, 0, 0, 5'd0, 32'h0,        mk(C_LW, 32'h22, 0, 32'hFFFFFFFC, 32'h014, 1, 2, 28));
        issue("sw",        32'h00112423, 32'h018, 0, 0, 5'd0, 32'h0,        mk(C_SW, 32'h22, 32'h11, 32'h8, 32'h018, 8, 2, 1));
        issue("beq",       32'hFE208CE3, 32'h01C, 0, 0, 5'd0, 32'h0,        mk(C_BEQ, 32'h11, 32'h22, 32'hFFFFFFF8, 32'h01C, 25, 1, 2));
        issue("jal",       32'h010000EF, 32'h200, 0, 0, 5'd0, 32'h0,        mk(C_JAL, 0, 0, 32'h10, 32'h200, 1, 0, 16));
        issue("addi_neg",  32'hFFF08213, 32'h204, 0, 0, 5'd0, 32'h0,        mk(C_ADDI, 32'h11, 0, 32'hFFFFFFFF, 32'h204, 4, 1, 31));
        issue("slt",       32'h0020A2B3, 32'h208, 0, 0, 5'd0, 32'h0,        mk(C_SLT, 32'h11, 32'h22, 32'h2, 32'h208, 5, 1, 2));
        issue("ori",       32'h0F016313, 32'h20C, 0, 0, 5'd0, 32'h0,        mk(C_ORI, 32'h22, 0, 32'hF0, 32'h20C, 6, 2, 16));
        issue("and",       32'h0020F3B3, 32'h210, 0, 0, 5'd0, 32'h0,        mk(C_AND, 32'h11, 32'h22, 32'h2, 32'h210, 7, 1, 2));
        issue("sll_add",   32'h002092B3, 32'h214, 0, 0, 5'd0, 32'h0,        mk(C_ADD, 32'h11, 32'h22, 32'h2, 32'h214, 5, 1, 2));
        issue("lui_none",  32'h000012B7, 32'h218, 0, 0, 5'd0, 32'h0,        mk(C_NONE, 0, 0, 0, 32'h218, 5, 0, 0));
        issue("flush",     32'h403100B3, 32'h300, 1, 1, 5'd3, 32'h33,       '0);
        issue("sub_byp2",  32'h403100B3, 32'h300, 0, 1, 5'd3, 32'h77,       mk(C_SUB, 32'h22, 32'h77, 32'h403, 32'h300, 1, 2, 3));
        issue("pre_reset", 32'h002081B3, 32'h400, 0, 0, 5'd0, 32'h0,        mk(C_ADD, 32'h11, 32'h22, 32'h2, 32'h400, 3, 1, 2));
        idle();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_now("async_reset", '0);
        @(negedge clk);
        rst = 1'b1;
        issue("post_reset_rf", 32'h002081B3, 32'h500, 0, 0, 5'd0, 32'h0,    mk(C_ADD, 0, 0, 32'h2, 32'h500, 3, 1, 2));
        idle();
        repeat (2) @(negedge clk);

        // final report
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
